// File: rtl/sha256_pkg.sv
// SHA-256 round constants, initial hash value and the FIPS 180-4 logical functions.
// Shared by the byte-level top and the round engine.
package sha256_pkg;

  localparam logic [255:0] H_INIT = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_compress.sv
// SHA-256 round engine: load latches a block and chaining value, then one round per en cycle.
// Latency 64 en cycles after load; rnd_last flags the cycle performing round 63, no backpressure.
module sha256_compress
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [511:0] block,
  input  logic [255:0] h_in,
  output logic [255:0] work,
  output logic         rnd_last
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] w [0:15];
  logic [5:0]  rnd;
  logic [31:0] t1, t2, w_next;

  always_comb begin
    t1     = h + big_sigma1(e) + ch(e, f, g) + K[rnd] + w[0];
    t2     = big_sigma0(a) + maj(a, b, c);
    // w[0] always holds W[rnd]; the schedule word entering at w[15] is W[rnd+16]
    w_next = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {a, b, c, d, e, f, g, h} <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
      rnd <= '0;
    end else if (load) begin
      {a, b, c, d, e, f, g, h} <= h_in;
      for (int i = 0; i < 16; i++) w[i] <= block[511-32*i -: 32];
      rnd <= '0;
    end else if (en) begin
      h <= g;
      g <= f;
      f <= e;
      e <= d + t1;
      d <= c;
      c <= b;
      b <= a;
      a <= t1 + t2;
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= w_next;
      rnd   <= rnd + 6'd1;
    end
  end

  assign work     = {a, b, c, d, e, f, g, h};
  assign rnd_last = (rnd == 6'd63);

endmodule

// File: rtl/sha256_top.sv
// SHA-256 byte-stream hasher: digest 66 cycles after the final byte, +65 per extra block.
// ready drops while a block compresses; bytes offered with ready=0 are dropped, not buffered.
module sha256_top
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   data_in,
  input  logic         data_valid,
  input  logic         last_byte,
  output logic [255:0] hash_out,
  output logic         hash_valid,
  output logic         ready
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PAD      = 3'd1;
  localparam logic [2:0] S_COMPRESS = 3'd2;
  localparam logic [2:0] S_UPDATE   = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]   state;
  logic [511:0] blk;
  logic [6:0]   cnt;
  logic [63:0]  bit_len;
  logic         msg_active, fin, pad2_pend;
  logic [255:0] h, h_sum, work, cmp_h;
  logic [511:0] pad1, pad2, cmp_block;
  logic         accept, start, blk_full, cmp_load, rnd_last;

  assign ready    = (state == S_IDLE) || (state == S_DONE);
  assign accept   = data_valid && ready;
  assign start    = ready && !msg_active && (data_valid || last_byte);
  assign blk_full = accept && !last_byte && (cnt == 7'd63);
  assign hash_out = h;

  always_comb begin
    pad1 = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < int'(cnt))       pad1[511-8*i -: 8] = blk[511-8*i -: 8];
      else if (i == int'(cnt)) pad1[511-8*i -: 8] = 8'h80;
    end
    if (cnt <= 7'd55) pad1[63:0] = bit_len;
    // A full final block pushes the 0x80 marker into the length-only block
    pad2 = '0;
    if (cnt == 7'd64) pad2[511:504] = 8'h80;
    pad2[63:0] = bit_len;
  end

  always_comb begin
    for (int i = 0; i < 8; i++) h_sum[32*i +: 32] = h[32*i +: 32] + work[32*i +: 32];
    cmp_load  = blk_full || (state == S_PAD) || ((state == S_UPDATE) && pad2_pend);
    cmp_block = {blk[511:8], data_in};
    cmp_h     = h;
    if (state == S_PAD) begin
      cmp_block = pad1;
    end else if (state == S_UPDATE) begin
      cmp_block = pad2;
      cmp_h     = h_sum;
    end
  end

  sha256_compress u_compress (
    .clk      (clk),
    .reset    (reset),
    .load     (cmp_load),
    .en       (state == S_COMPRESS),
    .block    (cmp_block),
    .h_in     (cmp_h),
    .work     (work),
    .rnd_last (rnd_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      blk        <= '0;
      cnt        <= '0;
      bit_len    <= '0;
      msg_active <= 1'b0;
      fin        <= 1'b0;
      pad2_pend  <= 1'b0;
      h          <= '0;
      hash_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            h          <= H_INIT;
            hash_valid <= 1'b0;
            msg_active <= 1'b1;
          end
          if (accept) begin
            bit_len <= (start ? 64'd0 : bit_len) + 64'd8;
            for (int i = 0; i < 64; i++)
              if (i == int'(cnt)) blk[511-8*i -: 8] <= data_in;
            if (last_byte) begin
              cnt   <= cnt + 7'd1;
              fin   <= 1'b1;
              state <= S_PAD;
            end else if (cnt == 7'd63) begin
              cnt   <= '0;
              state <= S_COMPRESS;
            end else begin
              cnt   <= cnt + 7'd1;
              state <= S_IDLE;
            end
          end else if (start) begin
            bit_len <= '0;
            fin     <= 1'b1;
            state   <= S_PAD;
          end else begin
            state <= S_IDLE;
          end
        end
        S_PAD: begin
          pad2_pend <= (cnt >= 7'd56);
          state     <= S_COMPRESS;
        end
        S_COMPRESS: begin
          if (rnd_last) state <= S_UPDATE;
        end
        S_UPDATE: begin
          h <= h_sum;
          if (pad2_pend) begin
            pad2_pend <= 1'b0;
            state     <= S_COMPRESS;
          end else if (fin) begin
            hash_valid <= 1'b1;
            msg_active <= 1'b0;
            fin        <= 1'b0;
            cnt        <= '0;
            state      <= S_DONE;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_top.sv
// Directed-vector bench for sha256_top: known digests, latencies, stalls, reset abort.
`timescale 1ns/1ps
module tb_sha256_top;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   data_in;
  logic         data_valid;
  logic         last_byte;
  logic [255:0] hash_out;
  logic         hash_valid;
  logic         ready;

  always #5 clk = ~clk;

  sha256_top dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .last_byte  (last_byte),
    .hash_out   (hash_out),
    .hash_valid (hash_valid),
    .ready      (ready)
  );

  typedef struct {
    int           kind;
    logic [255:0] digest;
    int           lat;
  } vec_t;

  localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_A     = 256'hca978112_ca1bbdca_fac231b3_9a23dc4d_a786eff8_147c4e72_b9807785_afee48bb;
  localparam logic [255:0] D_448   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] D_896   = 256'hcf5b16a7_78af8380_036ce59e_7b049237_0b249b11_e8f07a51_afac4503_7afee9d1;

  vec_t       vecs [0:4];
  logic [7:0] msg [0:127];
  int         msg_len;
  int         n_cmp = 0;
  int         n_bad = 0;
  time        t_acc;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // kind 0 empty, 1 "abc", 2 "a", 3 56-byte abcdbcde.., 4 112-byte abcdefghbcdefghi..
  task automatic build(input int kind);
    case (kind)
      1: begin msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63; msg_len = 3; end
      2: begin msg[0] = 8'h61; msg_len = 1; end
      3: begin
        for (int g = 0; g < 14; g++)
          for (int j = 0; j < 4; j++) msg[g*4+j] = 8'(8'h61 + g + j);
        msg_len = 56;
      end
      4: begin
        for (int g = 0; g < 14; g++)
          for (int j = 0; j < 8; j++) msg[g*8+j] = 8'(8'h61 + g + j);
        msg_len = 112;
      end
      default: msg_len = 0;
    endcase
  endtask

  // Called #1 after an edge; spurious_at inserts a data_valid=0/last_byte=1 cycle before that byte
  task automatic send_bytes(input int spurious_at);
    int n;
    if (msg_len == 0) begin
      check("empty_ready", 256'(ready), 256'(1));
      last_byte = 1'b1;
      @(posedge clk);
      t_acc = $time;
      #1 last_byte = 1'b0;
      check("empty_clears_valid", 256'(hash_valid), 256'(0));
    end
    for (int i = 0; i < msg_len; i++) begin
      if (i == spurious_at) begin
        data_valid = 1'b0;
        last_byte  = 1'b1;
        @(posedge clk);
        #1 last_byte = 1'b0;
      end
      if (!ready) begin
        n = 0;
        while (!ready && n < 200) begin
          @(posedge clk);
          #1 n++;
        end
        check("block_stall_cycles", 256'(n), 256'(65));
      end
      data_in    = msg[i];
      data_valid = 1'b1;
      last_byte  = (i == msg_len - 1);
      @(posedge clk);
      t_acc = $time;
      #1;
      data_valid = 1'b0;
      last_byte  = 1'b0;
      if (i == 0) check("start_clears_valid", 256'(hash_valid), 256'(0));
    end
  endtask

  // Junk bytes are offered throughout the busy period and must be ignored
  task automatic wait_digest(input string name, input logic [255:0] exp, input int lat);
    int n;
    bit ready_seen;
    n = 0;
    ready_seen = 1'b0;
    while (!hash_valid && n < 400) begin
      if (ready) ready_seen = 1'b1;
      data_in    = 8'($urandom);
      data_valid = 1'b1;
      last_byte  = 1'($urandom);
      @(posedge clk);
      #1 n++;
    end
    data_valid = 1'b0;
    last_byte  = 1'b0;
    check({name, "_ready_while_busy"}, 256'(ready_seen), 256'(0));
    check({name, "_hash_valid"}, 256'(hash_valid), 256'(1));
    check({name, "_digest"}, hash_out, exp);
    check({name, "_latency"}, 256'(($time - 1 - t_acc) / 10), 256'(lat));
    check({name, "_ready_at_done"}, 256'(ready), 256'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{kind: 0, digest: D_EMPTY, lat: 66};
    vecs[1] = '{kind: 1, digest: D_ABC,   lat: 66};
    vecs[2] = '{kind: 2, digest: D_A,     lat: 66};
    vecs[3] = '{kind: 3, digest: D_448,   lat: 131};
    vecs[4] = '{kind: 4, digest: D_896,   lat: 66};

    reset      = 1'b1;
    data_in    = 8'h00;
    data_valid = 1'b0;
    last_byte  = 1'b0;
    #2;
    check("reset_hash_out", hash_out, 256'(0));
    check("reset_hash_valid", 256'(hash_valid), 256'(0));
    check("reset_ready", 256'(ready), 256'(1));
    @(posedge clk);
    #1 reset = 1'b0;

    // Back-to-back: each message starts in the DONE cycle of the previous one
    for (int v = 0; v < 5; v++) begin
      build(vecs[v].kind);
      send_bytes(-1);
      wait_digest($sformatf("vec%0d", v), vecs[v].digest, vecs[v].lat);
    end

    repeat (3) @(posedge clk);
    #1;
    check("hold_digest", hash_out, D_896);
    check("hold_valid", 256'(hash_valid), 256'(1));

    // Abort mid-compression with an asynchronous reset
    build(1);
    send_bytes(-1);
    repeat (20) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_hash_out", hash_out, 256'(0));
    check("abort_hash_valid", 256'(hash_valid), 256'(0));
    check("abort_ready", 256'(ready), 256'(1));
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (70) @(posedge clk);
    #1;
    check("abort_no_digest", 256'(hash_valid), 256'(0));

    // "abc" with a stray last_byte (no data) after the first byte
    build(1);
    send_bytes(1);
    wait_digest("abc_after_abort", D_ABC, 66);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
